load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   RV32I load/store unit between a CPU pipeline and a simple word bus.
//   One request is accepted at a time in IDLE. A legal, aligned request makes
//   one bus access in ACCESS. An illegal or misaligned request goes straight
//   to RESP with an error flag and makes no bus access.
//
// Handshakes:
//   req_valid/req_ready : a request is taken on a rising edge where both are 1.
//                         req_ready is 1 only in IDLE.
//                         req_valid seen in any other state is dropped, not queued.
//   mem_req/mem_ack     : mem_req and the mem_* qualifiers stay stable until the
//                         cycle in which mem_ack=1, which completes the access.
//                         mem_rdata is sampled in that same cycle.
//                         mem_ack seen outside ACCESS is ignored.
//   resp_valid          : a one-cycle pulse with no back-pressure. resp_rdata,
//                         resp_misaligned and resp_fault keep their values
//                         between pulses.
//
// Ports:
//   clk, reset                    clock, async active-high reset
//   req_valid/ready/write/funct3/addr/wdata   CPU request side
//   resp_valid/rdata/misaligned/fault         CPU response side
//   mem_req/we/addr/be/wdata, mem_ack/rdata   bus side
//   dbg_state                     current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
//
// Optional feature:
//   LSU_TIMEOUT_EN - when defined, an ACCESS with no mem_ack for TIMEOUT_CYCLES
//                    cycles is abandoned and reported as a fault.
module load_store_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_misaligned,
  output logic                  resp_fault,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            dbg_state
);

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("load_store_unit supports DATA_WIDTH=32 only");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("load_store_unit TIMEOUT_CYCLES must be 2..255");
  end

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [2:0]            f3_q, f3_d;
  logic                  write_q, write_d;
  logic [1:0]            off_q, off_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_mis_q, resp_mis_d;
  logic                  resp_fault_q, resp_fault_d;
`ifdef LSU_TIMEOUT_EN
  logic [7:0]            cnt_q, cnt_d;
`endif

  // Request decode, evaluated combinationally on the incoming request.
  logic                  req_legal;
  logic                  req_misaligned;
  logic [3:0]            st_be;
  logic [DATA_WIDTH-1:0] st_wdata;
  // Load data extraction, evaluated on the latched request.
  logic [DATA_WIDTH-1:0] ld_shifted;
  logic [DATA_WIDTH-1:0] ld_ext;

  always_comb begin
    req_legal = req_write ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                          : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    // Store lanes: the data is replicated across the lanes, so the bus sees
    // the right byte or half in every lane that mem_be selects.
    case (req_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << req_addr[1:0];
        st_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << req_addr[1:0];
        st_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = req_wdata;
      end
    endcase
  end

  always_comb begin
    ld_shifted = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      3'b001:  ld_ext = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      3'b100:  ld_ext = {24'd0, ld_shifted[7:0]};
      3'b101:  ld_ext = {16'd0, ld_shifted[15:0]};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    f3_d         = f3_q;
    write_d      = write_q;
    off_d        = off_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_mis_d   = resp_mis_q;
    resp_fault_d = resp_fault_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d        = 8'd0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          f3_d    = req_funct3;
          write_d = req_write;
          off_d   = req_addr[1:0];
          if (!req_legal || req_misaligned) begin
            // An illegal code takes priority over misalignment.
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            resp_fault_d = !req_legal;
            resp_mis_d   = req_legal;
          end else begin
            state_d     = S_ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = req_write;
            mem_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_be_d    = req_write ? st_be : 4'b1111;
            mem_wdata_d = req_write ? st_wdata : '0;
          end
        end
      end
      S_ACCESS: begin
        if (mem_ack) begin
          state_d      = S_RESP;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = write_q ? '0 : ld_ext;
          resp_mis_d   = 1'b0;
          resp_fault_d = 1'b0;
        end
`ifdef LSU_TIMEOUT_EN
        // cnt_q counts the ACCESS cycles already spent without an ack.
        else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d      = S_RESP;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
          resp_mis_d   = 1'b0;
          resp_fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      f3_q         <= 3'd0;
      write_q      <= 1'b0;
      off_q        <= 2'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_mis_q   <= 1'b0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      f3_q         <= f3_d;
      write_q      <= write_d;
      off_q        <= off_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_mis_q   <= resp_mis_d;
      resp_fault_q <= resp_fault_d;
    end
  end

`ifdef LSU_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end
`endif

  assign req_ready       = (state_q == S_IDLE);
  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;
  assign resp_misaligned = resp_mis_q;
  assign resp_fault      = resp_fault_q;
  assign mem_req         = mem_req_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_be          = mem_be_q;
  assign mem_wdata       = mem_wdata_q;
  assign dbg_state       = state_q;

endmodule
